// File: rtl/cnn_stream_feeder_if.sv
// Core-side port bundle of the CNN stream feeder: reset, pixel/weight stream and result return path.
// The feeder owns the master side; the CNN core (or its bench model) owns the slave side.
interface cnn_stream_feeder_if #(
    parameter int BitSize      = 4,
    parameter int M_W_BitSize  = 4,
    parameter int MaxNumNerves = 4,
    parameter int L1Nerves     = 2
);
    logic                                core_res_n;
    logic                                core_in_valid;
    logic [BitSize-1:0]                  core_in_data;
    logic [MaxNumNerves*M_W_BitSize-1:0] core_in_weights;
    logic                                core_out_ready;
    logic                                core_out_valid;
    logic [L1Nerves*BitSize-1:0]         core_out_data;
    logic                                core_out_done;

    modport master (
        output core_res_n, core_in_valid, core_in_data, core_in_weights,
        input  core_out_ready, core_out_valid, core_out_data, core_out_done
    );

    modport slave (
        input  core_res_n, core_in_valid, core_in_data, core_in_weights,
        output core_out_ready, core_out_valid, core_out_data, core_out_done
    );
endinterface

// File: rtl/cnn_stream_feeder.sv
// Stimulus/collection engine for the CNN+DNN core: resets it, streams weight rows then pixels,
// and captures result beats until the core reports completion.
module cnn_stream_feeder #(
    parameter int BitSize      = 4,
    parameter int ImageWidth   = 8,
    parameter int Stride       = 2,
    parameter int M_W_BitSize  = 4,
    parameter int MaxNumNerves = 4,
    parameter int L0Nerves     = 4,
    parameter int L1Nerves     = 2
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic                                wr_en,
    input  logic                                wr_sel,
    input  logic [$clog2(ImageWidth*ImageWidth)-1:0] wr_addr,
    input  logic [MaxNumNerves*M_W_BitSize-1:0] wr_data,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    cnn_stream_feeder_if.master                 core,
    output logic [L1Nerves*BitSize-1:0]         result,
    output logic [7:0]                          beat_count
);
    localparam int NumPix    = ImageWidth * ImageWidth;
    localparam int ImageSize = (ImageWidth / (Stride ** 2)) ** 2;
    localparam int NumRows   = ImageSize + L0Nerves;
    localparam int AddrW     = $clog2(NumPix);
    localparam int RowIdxW   = $clog2(NumRows);
    localparam int RowW      = $clog2(NumRows + 1);
    localparam int WRowW     = MaxNumNerves * M_W_BitSize;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        W_LOAD   = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                      state_r, next_state_s;
    logic [BitSize-1:0]          pix_mem_r [NumPix];
    logic [WRowW-1:0]            wgt_mem_r [NumRows];
    logic [RowW-1:0]             wptr_r;
    logic [AddrW-1:0]            p_r, p_next_s;
    logic                        xfer_s, done_seen_r, capture_s;
    logic                        busy_r, done_r, core_res_n_r, in_valid_r;
    logic                        busy_s, done_s, core_res_n_s, in_valid_s;
    logic [BitSize-1:0]          in_data_r;
    logic [WRowW-1:0]            in_weights_r;
    logic [L1Nerves*BitSize-1:0] result_r;
    logic [7:0]                  beat_count_r;

    assign xfer_s    = in_valid_r && core.core_out_ready;
    assign p_next_s  = p_r + AddrW'(1);
    assign capture_s = (state_r == W_LOAD) || (state_r == STREAM) ||
                       (state_r == DRAIN)  || (state_r == DONE);

    // Host buffer writes; buffers survive reset and are frozen while a run is active.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_r) begin
            if (!wr_sel) begin
                pix_mem_r[wr_addr] <= wr_data[BitSize-1:0];
            end else if (int'(wr_addr) < NumRows) begin
                wgt_mem_r[wr_addr[RowIdxW-1:0]] <= wr_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (res_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = CORE_RST;
                else       next_state_s = IDLE;
            end
            CORE_RST: next_state_s = W_LOAD;
            W_LOAD: begin
                if (wptr_r == RowW'(NumRows)) next_state_s = STREAM;
                else                          next_state_s = W_LOAD;
            end
            STREAM: begin
                if (xfer_s && (p_r == AddrW'(NumPix - 1))) next_state_s = DRAIN;
                else                                       next_state_s = STREAM;
            end
            DRAIN: begin
                if (done_seen_r || core.core_out_done) next_state_s = DONE;
                else                                   next_state_s = DRAIN;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Control outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        busy_s       = (next_state_s != IDLE);
        done_s       = (next_state_s == DONE);
        core_res_n_s = (next_state_s != CORE_RST);
        in_valid_s   = (next_state_s == STREAM);
    end

    // Registered control outputs; the core is held in reset while this block is.
    always_ff @(posedge clk) begin
        if (res_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            core_res_n_r <= 1'b0;
            in_valid_r   <= 1'b0;
        end else begin
            busy_r       <= busy_s;
            done_r       <= done_s;
            core_res_n_r <= core_res_n_s;
            in_valid_r   <= in_valid_s;
        end
    end

    // Datapath: weight/pixel pointers, streamed data and result capture.
    always_ff @(posedge clk) begin
        if (res_n) begin
            wptr_r       <= '0;
            p_r          <= '0;
            in_data_r    <= '0;
            in_weights_r <= '0;
            result_r     <= '0;
            beat_count_r <= 8'd0;
            done_seen_r  <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                wptr_r <= '0;
            end else if (next_state_s == W_LOAD) begin
                wptr_r <= wptr_r + RowW'(1);
            end

            if (next_state_s == W_LOAD) begin
                in_weights_r <= wgt_mem_r[wptr_r[RowIdxW-1:0]];
            end else begin
                in_weights_r <= '0;
            end

            if (next_state_s == STREAM) begin
                if (state_r != STREAM) begin
                    p_r       <= '0;
                    in_data_r <= pix_mem_r[0];
                end else if (xfer_s) begin
                    p_r       <= p_next_s;
                    in_data_r <= pix_mem_r[p_next_s];
                end
            end else begin
                in_data_r <= '0;
            end

            if (state_r == CORE_RST) begin
                result_r     <= '0;
                beat_count_r <= 8'd0;
                done_seen_r  <= 1'b0;
            end else if (capture_s) begin
                if (core.core_out_valid) begin
                    result_r <= core.core_out_data;
                    if (beat_count_r != 8'hFF) beat_count_r <= beat_count_r + 8'd1;
                end
                // An early completion must survive until the stream has drained.
                if (core.core_out_done && ((state_r == W_LOAD) || (state_r == STREAM))) begin
                    done_seen_r <= 1'b1;
                end
            end
        end
    end

    assign busy                 = busy_r;
    assign done                 = done_r;
    assign result               = result_r;
    assign beat_count           = beat_count_r;
    assign core.core_res_n      = core_res_n_r;
    assign core.core_in_valid   = in_valid_r;
    assign core.core_in_data    = in_data_r;
    assign core.core_in_weights = in_weights_r;
endmodule

// File: tb/tb_cnn_stream_feeder.sv
// Scoreboard bench for cnn_stream_feeder: expected weight rows and pixels are queued from a host
// buffer model at run start and popped as the DUT presents/transfers them.
module tb_cnn_stream_feeder;
    localparam int NumPix  = 64;
    localparam int NumRows = 8;

    logic        clk = 1'b0;
    logic        res_n, wr_en, wr_sel, start, busy, done;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  result, beat_count;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  pix_m [NumPix];
    logic [15:0] wgt_m [NumRows];
    logic [15:0] wq [$];
    logic [3:0]  pq [$];

    always #5 clk = ~clk;

    cnn_stream_feeder_if #(.BitSize(4), .M_W_BitSize(4), .MaxNumNerves(4), .L1Nerves(2)) cif ();

    cnn_stream_feeder dut (
        .clk        (clk),
        .res_n      (res_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .core       (cif.master),
        .result     (result),
        .beat_count (beat_count)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic sel, input logic [5:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 0: ready=1, beats in DRAIN; mode 1: backpressure, illegal write/start, early done;
    // mode 2: abort by reset at pixel 20.
    task automatic run(input int mode);
        int   cyc, xfers, budget, hold5, stall_left;
        logic stalled, alt, rdy, prev_valid, prev_xfer, aborted, beat_sent, got_done;
        logic [3:0] prev_data;
        wq.delete(); pq.delete();
        for (int k = 0; k < NumRows; k++) wq.push_back(wgt_m[k]);
        for (int i = 0; i < NumPix; i++) pq.push_back(pix_m[i]);

        start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        check_val("rst_pulse_core_res_n", cif.core_res_n, 1'b0);
        check_val("rst_pulse_busy", busy, 1'b1);
        check_val("rst_pulse_valid", cif.core_in_valid, 1'b0);

        for (int k = 0; k < NumRows; k++) begin
            @(negedge clk); cyc++;
            check_val("wload_core_res_n", cif.core_res_n, 1'b1);
            check_val("wload_valid", cif.core_in_valid, 1'b0);
            check_val("wload_row", cif.core_in_weights, wq.pop_front());
            if (mode == 1 && k == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd3; wr_data = 16'h000F; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
        end

        xfers = 0; budget = 0; hold5 = 0; stall_left = 0;
        stalled = 1'b0; alt = 1'b0; prev_valid = 1'b0; prev_xfer = 1'b0;
        aborted = 1'b0; beat_sent = 1'b0; prev_data = 4'h0;
        while (xfers < NumPix && budget < 400) begin
            @(negedge clk); cyc++; budget++;
            cif.core_out_valid = 1'b0; cif.core_out_done = 1'b0;
            check_val("stream_valid", cif.core_in_valid, 1'b1);
            if (!cif.core_in_valid) break;
            if (xfers == 0) check_val("weights_cleared", cif.core_in_weights, 16'h0000);
            if (mode == 0 && xfers == 0) check_val("first_pix_cyc", cyc, 10);
            if (prev_valid && !prev_xfer) check_val("hold_stable", cif.core_in_data, prev_data);
            if (mode == 2 && xfers == 20) begin
                aborted = 1'b1; res_n = 1'b1;
                break;
            end
            if (mode == 1) begin
                if (xfers == 5 && !stalled) begin stalled = 1'b1; stall_left = 3; end
                if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
                else if (xfers > 5) begin rdy = alt; alt = !alt; end
                else rdy = 1'b1;
            end else begin
                rdy = 1'b1;
            end
            if (xfers == 5) hold5++;
            if (mode == 1 && xfers == 30 && !beat_sent) begin
                beat_sent = 1'b1;
                cif.core_out_valid = 1'b1; cif.core_out_data = 8'h5A; cif.core_out_done = 1'b1;
            end
            cif.core_out_ready = rdy;
            prev_valid = 1'b1; prev_xfer = rdy; prev_data = cif.core_in_data;
            if (rdy) begin
                check_val("pix", cif.core_in_data, pq.pop_front());
                xfers++;
                if (mode == 0 && xfers == NumPix) check_val("last_pix_cyc", cyc, 73);
            end
        end
        cif.core_out_ready = 1'b1;

        if (aborted) begin
            @(negedge clk);
            check_val("abort_valid", cif.core_in_valid, 1'b0);
            check_val("abort_busy", busy, 1'b0);
            check_val("abort_core_res_n", cif.core_res_n, 1'b0);
            res_n = 1'b0;
            @(negedge clk);
            check_val("abort_release_core_res_n", cif.core_res_n, 1'b1);
            check_val("abort_release_busy", busy, 1'b0);
            return;
        end

        check_val("xfer_count", xfers, NumPix);
        if (mode == 1) check_val("pix5_hold_cycles", hold5, 4);
        @(negedge clk); cyc++;
        check_val("valid_drop", cif.core_in_valid, 1'b0);
        if (mode == 0) check_val("valid_drop_cyc", cyc, 74);

        if (mode == 0) begin
            cif.core_out_valid = 1'b1; cif.core_out_data = 8'h21;
        end
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got_done = 1'b1; break; end
            if (mode == 0 && i == 0) cif.core_out_data = 8'h43;
            if (mode == 0 && i == 1) begin cif.core_out_valid = 1'b0; cif.core_out_done = 1'b1; end
            if (i >= 2) cif.core_out_done = 1'b0;
        end
        cif.core_out_valid = 1'b0; cif.core_out_done = 1'b0;
        check_val("done_seen", got_done, 1'b1);
        check_val("busy_at_done", busy, 1'b1);
        check_val("result", result, (mode == 0) ? 8'h43 : 8'h5A);
        check_val("beat_count", beat_count, (mode == 0) ? 8'd2 : 8'd1);
        @(negedge clk);
        check_val("done_one_cycle", done, 1'b0);
        check_val("busy_after_done", busy, 1'b0);
        @(negedge clk);
        check_val("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 16'h0000; start = 1'b0;
        cif.core_out_ready = 1'b1; cif.core_out_valid = 1'b0;
        cif.core_out_data = 8'h00; cif.core_out_done = 1'b0;

        repeat (3) @(negedge clk);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", done, 1'b0);
        check_val("reset_core_res_n", cif.core_res_n, 1'b0);
        check_val("reset_valid", cif.core_in_valid, 1'b0);
        check_val("reset_data", cif.core_in_data, 4'h0);
        check_val("reset_weights", cif.core_in_weights, 16'h0000);
        check_val("reset_result", result, 8'h00);
        check_val("reset_beat_count", beat_count, 8'd0);
        res_n = 1'b0;
        @(negedge clk);
        check_val("post_reset_core_res_n", cif.core_res_n, 1'b1);
        check_val("post_reset_busy", busy, 1'b0);

        wgt_m[0] = 16'h1000; wgt_m[1] = 16'h0100; wgt_m[2] = 16'h0000; wgt_m[3] = 16'h0000;
        wgt_m[4] = 16'h1010; wgt_m[5] = 16'h0101; wgt_m[6] = 16'h1100; wgt_m[7] = 16'h0011;
        for (int k = 0; k < NumRows; k++) host_write(1'b1, 6'(k), wgt_m[k]);
        host_write(1'b1, 6'd8, 16'hFFFF);
        for (int i = 0; i < NumPix; i++) begin
            pix_m[i] = 4'(i % 16);
            host_write(1'b0, 6'(i), {12'h000, pix_m[i]});
        end

        run(0);
        run(1);
        run(2);
        run(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cnn_stream_feeder.md
Name: cnn_stream_feeder

Overview:
- Hardware stimulus/collection engine for the CNN+DNN `top` core; it drives the same port set that bench software drives today.
- Host preloads a pixel buffer and a weight buffer, then pulses `start`.
- The block resets the core, streams DNN weight rows one per cycle, then streams image pixels under valid/ready backpressure.
- It captures DNN output beats until the core signals `out_done`.

Parameters:
- BitSize, 4, pixel and DNN output element width
- ImageWidth, 8, image side; the pixel count is ImageWidth*ImageWidth
- Stride, 2, pooling stride; ImageSize = (ImageWidth/(Stride**2))**2 (localparam, 4 at defaults)
- M_W_BitSize, 4, DNN weight width
- MaxNumNerves, 4, weight row width in elements
- L0Nerves, 4, nerves in the first DNN layer; also the number of layer-1 weight rows
- L1Nerves, 2, nerves in the output layer; width of the captured result in elements

Ports:
- clk  in  1  single clock; all logic on posedge
- res_n  in  1  reset; synchronous, active-high (1 = reset)
- wr_en  in  1  host buffer write strobe
- wr_sel  in  1  0 = pixel buffer, 1 = weight buffer
- wr_addr  in  $clog2(ImageWidth*ImageWidth)  buffer address
- wr_data  in  MaxNumNerves*M_W_BitSize  write data; pixel writes use bits [BitSize-1:0]
- start  in  1  single-cycle run request
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse at the end of a run
- core_res_n  out  1  active-low reset to the core
- core_in_valid  out  1  pixel valid
- core_in_data  out  BitSize  pixel
- core_in_weights  out  MaxNumNerves*M_W_BitSize  weight row
- core_out_ready  in  1  core accepts a pixel
- core_out_valid  in  1  DNN result beat valid
- core_out_data  in  L1Nerves*BitSize  DNN result beat
- core_out_done  in  1  core finished
- result  out  L1Nerves*BitSize  last captured beat
- beat_count  out  8  number of beats captured this run

Behaviour:
- Reset (res_n=1 at posedge):
  - state = IDLE; busy = 0, done = 0, core_in_valid = 0, core_in_data = 0, core_in_weights = 0, result = 0, beat_count = 0.
  - core_res_n = 0 while res_n is high.
  - Buffers are not cleared.
  - Reset mid-run aborts immediately to IDLE.
- Buffers:
  - Pixel buffer has ImageWidth² entries; address 0 is the first pixel sent (top-left).
  - Weight buffer has ImageSize+L0Nerves rows. Rows 0..ImageSize-1 are layer-0 rows; the following rows are layer-1 rows. Each row is presented verbatim, including its zero padding.
  - Writes are accepted only when busy = 0; writes while busy are dropped.
  - Out-of-range weight addresses are dropped.
- States:
  - IDLE: core_res_n = 1. start=1 → CORE_RST. start while busy is ignored.
  - CORE_RST: exactly one cycle with core_res_n = 0; beat_count and result cleared. Next state W_LOAD.
  - W_LOAD: row k is driven on core_in_weights in the k-th W_LOAD cycle, for k = 0..ImageSize+L0Nerves-1. Exactly one row per cycle, with no backpressure. core_in_valid = 0. After the last row, core_in_weights returns to 0 and the state goes to STREAM.
  - STREAM:
    - core_in_valid = 1 and core_in_data = pix[p].
    - A pixel transfers at a posedge where core_in_valid && core_out_ready; p then increments and the next pixel appears the following cycle.
    - core_in_data is held stable while ready = 0.
    - After pixel ImageWidth²-1 transfers, core_in_valid drops in the next cycle and the state goes to DRAIN.
  - DRAIN: waits for core_out_done. There is no timeout.
  - DONE: one cycle; done = 1. Next state IDLE; busy falls in the same cycle as done falls.
- Result capture (any state after CORE_RST):
  - Each cycle with core_out_valid = 1 loads result from core_out_data and increments beat_count, saturating at 255.
  - core_out_done seen during STREAM is latched and honoured on entry to DRAIN; DRAIN then exits next cycle.
  - core_out_valid and core_out_done in the same cycle: the beat is captured, then the done transition is taken.
- Latency, with start sampled at cycle T:
  - CORE_RST at T+1.
  - Weight rows at T+2 .. T+1+ImageSize+L0Nerves.
  - First pixel at T+2+ImageSize+L0Nerves.
  - With ready held at 1, the last pixel is at T+1+ImageSize+L0Nerves+ImageWidth².

Test Plan:
- Reset default:
  - Stimulus: hold res_n=1 for 3 cycles, then release.
  - Required: all outputs at their reset values; core_res_n=0 during reset and 1 after; busy=0.
- Weight sequencing:
  - Stimulus: preload rows 0..7 with {A,D,0,0},{D,A,0,0},{D,D,0,0},{D,D,0,0},{A,D,A,D},{D,A,D,A},… (A=4'h1, D=0); start at T.
  - Required: core_res_n=0 only at T+1; rows appear in order at T+2..T+9; core_in_valid=0 throughout.
- Pixel streaming with ready=1:
  - Stimulus: pixel buffer loaded with 64 values (pix[i] = i mod 16).
  - Required: core_in_data = i mod 16 on consecutive cycles T+10..T+73; valid drops at T+74.
- Backpressure:
  - Stimulus: drop core_out_ready for 3 cycles at pixel 5, then drop it every other cycle.
  - Required: pixel 5 is held for 4 cycles; no pixel is skipped or duplicated; 64 transfers counted.
- Capture/done:
  - Stimulus: core emits beats 8'h21 then 8'h43 during DRAIN, then core_out_done.
  - Required: result=8'h43, beat_count=2, a one-cycle done, and busy=0 the cycle after done.
- Abort and illegal requests:
  - Stimulus: res_n=1 during STREAM at pixel 20; separately, a wr_en and a start asserted while busy.
  - Required: immediate IDLE with valid=0. The write is dropped (buffer readback is unchanged on the next run). The start is ignored.
